serial_bcd_sequencer: RTL and testbench

SERIAL_BCD_SEQUENCER -- requirements
Module: serial_bcd_sequencer

---
 rtl/serial_bcd_sequencer.sv | 139 +++++++++++++
 tb/tb_serial_bcd_sequencer.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_bcd_sequencer.sv
// Moore control FSM that sequences one serial operand-in / BCD result-out frame.
// Define SERIAL_BCD_SEQ_ABORT_EN to add an abort input that drops any frame back to IDLE.
module serial_bcd_sequencer #(
    parameter int IN_BITS       = 33,
    parameter int OUT_BITS      = 20,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
`ifdef SERIAL_BCD_SEQ_ABORT_EN
    input  logic       abort,
`endif
    output logic       sipo_en,
    output logic       piso_load,
    output logic       piso_shift,
    output logic [5:0] bit_idx,
    output logic       ready,
    output logic       done
);

    localparam int CNT_W = 6;
    localparam logic [CNT_W-1:0] IN_LAST     = CNT_W'(IN_BITS - 1);
    localparam logic [CNT_W-1:0] OUT_LAST    = CNT_W'(OUT_BITS - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SETTLE,
        CAPTURE,
        SHIFT,
        DONE
    } state_t;

    state_t           state, state_nx;
    logic [CNT_W-1:0] cnt,   cnt_nx;
    logic             abort_req;

`ifdef SERIAL_BCD_SEQ_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    // NOTE: defaults are assigned before the case so no path through this block infers a latch.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        unique case (state)
            IDLE: begin
                if (start && !abort_req) begin
                    state_nx = LOAD;
                    cnt_nx   = '0;
                end
            end
            LOAD: begin
                if (cnt == IN_LAST) begin
                    state_nx = (SETTLE_CYCLES > 0) ? SETTLE : CAPTURE;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + CNT_ONE;
                end
            end
            SETTLE: begin
                if (cnt == SETTLE_LAST) begin
                    state_nx = CAPTURE;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + CNT_ONE;
                end
            end
            CAPTURE: begin
                state_nx = SHIFT;
                cnt_nx   = '0;
            end
            SHIFT: begin
                if (cnt == OUT_LAST) begin
                    state_nx = DONE;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt + CNT_ONE;
                end
            end
            DONE: begin
                state_nx = IDLE;
                cnt_nx   = '0;
            end
            default: begin
                state_nx = IDLE;
                cnt_nx   = '0;
            end
        endcase

        // Abort wins over every in-frame transition; IDLE already handled it above.
        if (abort_req && state != IDLE) begin
            state_nx = IDLE;
            cnt_nx   = '0;
        end
    end

    // Outputs depend only on registered state and counter.
    always_comb begin
        sipo_en    = 1'b0;
        piso_load  = 1'b0;
        piso_shift = 1'b0;
        bit_idx    = '0;
        ready      = 1'b0;
        done       = 1'b0;
        unique case (state)
            IDLE:    ready = 1'b1;
            LOAD: begin
                sipo_en = 1'b1;
                bit_idx = cnt;
            end
            SETTLE:  ;
            CAPTURE: piso_load = 1'b1;
            SHIFT: begin
                piso_shift = 1'b1;
                bit_idx    = cnt;
            end
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_serial_bcd_sequencer.sv
// Randomized and directed bench for serial_bcd_sequencer against a frame-position model.
// Two instances run in parallel: default parameters and a short frame with no settle gap.
module tb_serial_bcd_sequencer;

    typedef struct packed {
        logic       sipo;
        logic       load;
        logic       shift;
        logic       ready;
        logic       done;
        logic [5:0] idx;
    } obs_t;

    logic       clk;
    logic       rst;
    logic       start;
    logic       abort;
    logic       d_sipo  [2];
    logic       d_load  [2];
    logic       d_shift [2];
    logic [5:0] d_idx   [2];
    logic       d_ready [2];
    logic       d_done  [2];

    int checks;
    int errors;
    int edge_cnt;
    int pos [2];
    int done_q0[$];
    int done_q1[$];

    serial_bcd_sequencer u_dut0 (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
`ifdef SERIAL_BCD_SEQ_ABORT_EN
        .abort      (abort),
`endif
        .sipo_en    (d_sipo[0]),
        .piso_load  (d_load[0]),
        .piso_shift (d_shift[0]),
        .bit_idx    (d_idx[0]),
        .ready      (d_ready[0]),
        .done       (d_done[0])
    );

    serial_bcd_sequencer #(
        .IN_BITS       (4),
        .OUT_BITS      (3),
        .SETTLE_CYCLES (0)
    ) u_dut1 (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
`ifdef SERIAL_BCD_SEQ_ABORT_EN
        .abort      (abort),
`endif
        .sipo_en    (d_sipo[1]),
        .piso_load  (d_load[1]),
        .piso_shift (d_shift[1]),
        .bit_idx    (d_idx[1]),
        .ready      (d_ready[1]),
        .done       (d_done[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic int p_in(int i);
        return (i == 0) ? 33 : 4;
    endfunction

    function automatic int p_set(int i);
        return (i == 0) ? 1 : 0;
    endfunction

    function automatic int p_out(int i);
        return (i == 0) ? 20 : 3;
    endfunction

    // Frame length in cycles, LOAD through DONE inclusive.
    function automatic int frame_len(int i);
        return p_in(i) + p_set(i) + 1 + p_out(i) + 1;
    endfunction

    // Expected outputs for a position within the frame (-1 means idle).
    function automatic obs_t model_out(int i, int p);
        obs_t o;
        int   k;
        o = '0;
        k = p;
        if (p < 0) begin
            o.ready = 1'b1;
        end else if (k < p_in(i)) begin
            o.sipo = 1'b1;
            o.idx  = 6'(k);
        end else begin
            k -= p_in(i);
            if (k >= p_set(i)) begin
                k -= p_set(i);
                if (k == 0) begin
                    o.load = 1'b1;
                end else begin
                    k -= 1;
                    if (k < p_out(i)) begin
                        o.shift = 1'b1;
                        o.idx   = 6'(k);
                    end else begin
                        o.done = 1'b1;
                    end
                end
            end
        end
        return o;
    endfunction

    task automatic compare_all();
        obs_t e;
        for (int i = 0; i < 2; i++) begin
            e = model_out(i, pos[i]);
            check($sformatf("d%0d sipo_en", i),    32'(d_sipo[i]),  32'(e.sipo));
            check($sformatf("d%0d piso_load", i),  32'(d_load[i]),  32'(e.load));
            check($sformatf("d%0d piso_shift", i), 32'(d_shift[i]), 32'(e.shift));
            check($sformatf("d%0d bit_idx", i),    32'(d_idx[i]),   32'(e.idx));
            check($sformatf("d%0d ready", i),      32'(d_ready[i]), 32'(e.ready));
            check($sformatf("d%0d done", i),       32'(d_done[i]),  32'(e.done));
            check($sformatf("d%0d exclusive", i),
                  32'($countones({d_sipo[i], d_load[i], d_shift[i]}) <= 1), 32'd1);
        end
    endtask

    // One clock: advance the model on the edge, compare on the falling edge.
    task automatic step();
        @(posedge clk);
        edge_cnt++;
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                pos[i] = -1;
            end else if (pos[i] < 0) begin
                if (start && !abort) pos[i] = 0;
            end else if (abort || pos[i] == frame_len(i) - 1) begin
                pos[i] = -1;
            end else begin
                pos[i]++;
            end
        end
        @(negedge clk);
        compare_all();
        if (d_done[0]) done_q0.push_back(edge_cnt);
        if (d_done[1]) done_q1.push_back(edge_cnt);
    endtask

    task automatic run(input int n);
        for (int c = 0; c < n; c++) step();
    endtask

    initial begin
        int s;
        checks   = 0;
        errors   = 0;
        edge_cnt = 0;
        pos[0]   = -1;
        pos[1]   = -1;
        rst      = 1'b1;
        start    = 1'b0;
        abort    = 1'b0;

        // Reset state before any clock edge.
        #1;
        compare_all();
        run(3);
        rst = 1'b0;
        run(2);

        // Single frame; extra starts at cycles 10 and 40 must be ignored by the long frame.
        done_q0.delete();
        done_q1.delete();
        start = 1'b1;
        step();
        s = edge_cnt;
        start = 1'b0;
        for (int c = 1; c < 62; c++) begin
            start = (c == 10 || c == 40);
            step();
        end
        start = 1'b0;
        check("single frame done count", 32'(done_q0.size()), 32'd1);
        if (done_q0.size() > 0) check("default latency", 32'(done_q0[0] - s + 1), 32'd56);
        if (done_q1.size() > 0) check("short latency", 32'(done_q1[0] - s + 1), 32'd9);
        else                    check("short frame done seen", 32'd0, 32'd1);
        run(10);

        // Continuous start: back-to-back frames 57 cycles apart.
        done_q0.delete();
        start = 1'b1;
        run(130);
        start = 1'b0;
        check("held start frame count", 32'(done_q0.size() >= 2), 32'd1);
        for (int k = 1; k < done_q0.size(); k++)
            check("held start spacing", 32'(done_q0[k] - done_q0[k-1]), 32'd57);
        run(60);

        // Reset in the middle of SHIFT abandons the frame immediately.
        done_q0.delete();
        start = 1'b1;
        step();
        s = edge_cnt;
        start = 1'b0;
        run(44);
        check("pre-reset in shift", 32'(d_shift[0]), 32'd1);
        rst = 1'b1;
        #1;
        check("async rst ready",      32'(d_ready[0]), 32'd1);
        check("async rst sipo_en",    32'(d_sipo[0]),  32'd0);
        check("async rst piso_load",  32'(d_load[0]),  32'd0);
        check("async rst piso_shift", 32'(d_shift[0]), 32'd0);
        check("async rst bit_idx",    32'(d_idx[0]),   32'd0);
        check("async rst done",       32'(d_done[0]),  32'd0);
        run(2);
        rst = 1'b0;
        run(3);
        check("no done after reset", 32'(done_q0.size()), 32'd0);
        start = 1'b1;
        step();
        s = edge_cnt;
        start = 1'b0;
        run(60);
        if (done_q0.size() == 1) check("post-reset latency", 32'(done_q0[0] - s + 1), 32'd56);
        else                     check("post-reset done count", 32'(done_q0.size()), 32'd1);

`ifdef SERIAL_BCD_SEQ_ABORT_EN
        // Abort inside LOAD, then abort together with start while idle.
        done_q0.delete();
        start = 1'b1;
        step();
        start = 1'b0;
        run(19);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("abort -> ready", 32'(d_ready[0]), 32'd1);
        start = 1'b1;
        abort = 1'b1;
        step();
        start = 1'b0;
        abort = 1'b0;
        check("abort+start stays idle", 32'(d_ready[0]), 32'd1);
        run(60);
        check("no done after abort", 32'(done_q0.size()), 32'd0);
`endif

        // Randomized traffic with occasional resets (and aborts when present).
        for (int c = 0; c < 3000; c++) begin
            start = ($urandom_range(3) == 0);
            rst   = ($urandom_range(299) == 0);
`ifdef SERIAL_BCD_SEQ_ABORT_EN
            abort = ($urandom_range(99) == 0);
`endif
            step();
        end
        rst   = 1'b0;
        start = 1'b0;
        abort = 1'b0;
        run(5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
